seq_alu: RTL and testbench

- Parametrised, registered successor to the combinational 8-bit ALU.
- Keeps the existing opcode map and the SC_in/Zero semantics.
- Adds a Start/Busy/Done handshake and multi-cycle ops: shift-and-add multiply, and shift by N (one bit per cycle).
- Sits between the register file and the writeback mux. The controller stalls on Busy and captures Out on Done.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 189 ++++++++++++++++++
 tb/tb_seq_alu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle between the pipeline controller and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic             SC_in;
  logic [3:0]       OP;
  logic [WIDTH-1:0] Out;
  logic             SC_out;
  logic             Zero;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, InputA, InputB, SC_in, OP,
    input  Out, SC_out, Zero, Busy, Done
  );

  modport slave (
    input  Start, InputA, InputB, SC_in, OP,
    output Out, SC_out, Zero, Busy, Done
  );
endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops, shift-add MUL,
// and bit-serial shift-by-N, behind a Start/Busy/Done handshake.
module seq_alu #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input logic      Clk,
  input logic      Reset,
  seq_alu_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W   = 2 * WIDTH;

  localparam logic [3:0] OP_LSH  = 4'b0000;
  localparam logic [3:0] OP_RSH  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SHLN = 4'b0100;
  localparam logic [3:0] OP_SHRN = 4'b0101;
  localparam logic [3:0] OP_GEQ  = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_NEG  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_NEQ  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e             state_q,   state_d;
  logic [3:0]         op_q,      op_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic               sc_in_q,   sc_in_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [SHAMT_W-1:0] cnt_q,     cnt_d;
  logic               sc_last_q, sc_last_d;
  logic [WIDTH-1:0]   out_q,     out_d;
  logic               sc_out_q,  sc_out_d;
  logic               zero_q,    zero_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic [SHAMT_W-1:0] shamt_c;
  logic [WIDTH:0]     add_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH-1:0]   res_c;
  logic               res_sc_c;

  // Shift count saturates at WIDTH so a large B never wraps the counter.
  always_comb begin
    shamt_c = (bus.InputB > WIDTH'(WIDTH)) ? SHAMT_W'(WIDTH)
                                           : bus.InputB[SHAMT_W-1:0];
  end

  // Adder and one shift-add multiply step (upper half += A if LSB set, then shift right).
  always_comb begin
    add_c     = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(sc_in_q);
    mul_sum_c = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  end

  // Final result from latched operands / accumulator, consumed in FINISH.
  always_comb begin
    res_c    = '0;
    res_sc_c = 1'b0;
    case (op_q)
      OP_LSH:  begin res_c = {a_q[WIDTH-2:0], sc_in_q}; res_sc_c = a_q[WIDTH-1]; end
      OP_RSH:  begin res_c = {sc_in_q, a_q[WIDTH-1:1]}; res_sc_c = a_q[0]; end
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_SHLN, OP_SHRN: begin res_c = acc_q[WIDTH-1:0]; res_sc_c = sc_last_q; end
      OP_GEQ:  res_c = WIDTH'(a_q >= b_q);
      OP_EQ:   res_c = WIDTH'(a_q == b_q);
      OP_NEQ:  res_c = WIDTH'(a_q != b_q);
      OP_NEG:  res_c = (~a_q) + WIDTH'(1);
      OP_ADD:  {res_sc_c, res_c} = add_c;
      OP_MUL: begin
        if (MUL_EN != 0) begin
          res_c    = acc_q[WIDTH-1:0];
          res_sc_c = |acc_q[ACC_W-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic for the IDLE/RUN/FINISH sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sc_in_d   = sc_in_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sc_last_d = sc_last_q;
    out_d     = out_q;
    sc_out_d  = sc_out_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          op_d      = bus.OP;
          a_d       = bus.InputA;
          b_d       = bus.InputB;
          sc_in_d   = bus.SC_in;
          busy_d    = 1'b1;
          sc_last_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_FINISH;
          if (bus.OP == OP_MUL && MUL_EN != 0) begin
            acc_d   = ACC_W'(bus.InputB);
            cnt_d   = SHAMT_W'(WIDTH);
            state_d = S_RUN;
          end else if (bus.OP == OP_SHLN || bus.OP == OP_SHRN) begin
            acc_d = ACC_W'(bus.InputA);
            cnt_d = shamt_c;
            if (shamt_c != '0) state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_FINISH;
        case (op_q)
          OP_SHLN: begin
            sc_last_d = acc_q[WIDTH-1];
            acc_d     = ACC_W'({acc_q[WIDTH-2:0], 1'b0});
          end
          OP_SHRN: begin
            sc_last_d = acc_q[0];
            acc_d     = ACC_W'(acc_q[WIDTH-1:1]);
          end
          default: acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        endcase
      end
      S_FINISH: begin
        out_d    = res_c;
        sc_out_d = res_sc_c;
        zero_d   = (res_c == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sc_in_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sc_last_q <= 1'b0;
      out_q     <= '0;
      sc_out_q  <= 1'b0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sc_in_q   <= sc_in_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sc_last_q <= sc_last_d;
      out_q     <= out_d;
      sc_out_q  <= sc_out_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Out    = out_q;
  assign bus.SC_out = sc_out_q;
  assign bus.Zero   = zero_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8), .MUL_EN(1)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request before an edge, hold Start through that edge only.
  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sc);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.OP     = op;
    bus.InputA = a;
    bus.InputB = b;
    bus.SC_in  = sc;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Count edges until Done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.Done && lat < 40);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic sc, input int exp_lat,
                        input logic [7:0] exp_out, input logic exp_sc, input logic exp_z);
    int lat;
    start_op(op, a, b, sc);
    wait_done(lat);
    check({tag, "_lat"},  32'(lat),        32'(exp_lat));
    check({tag, "_out"},  32'(bus.Out),    32'(exp_out));
    check({tag, "_sc"},   32'(bus.SC_out), 32'(exp_sc));
    check({tag, "_zero"}, 32'(bus.Zero),   32'(exp_z));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.Done), 32'(0));
    check({tag, "_hold"},  32'(bus.Out),  32'(exp_out));
  endtask

  initial begin
    int lat;
    bit done_seen;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.OP     = 4'h0;
    bus.InputA = 8'h00;
    bus.InputB = 8'h00;
    bus.SC_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  32'(bus.Out),    32'(0));
    check("rst_sc",   32'(bus.SC_out), 32'(0));
    check("rst_zero", 32'(bus.Zero),   32'(1));
    check("rst_busy", 32'(bus.Busy),   32'(0));
    check("rst_done", 32'(bus.Done),   32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a MUL.
    run_op("neg01", 4'b1010, 8'h01, 8'h00, 1'b0, 1, 8'hFF, 1'b0, 1'b0);
    start_op(4'b1100, 8'd13, 8'd11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.Busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_out",  32'(bus.Out),  32'(0));
    check("arst_zero", 32'(bus.Zero), 32'(1));
    check("arst_busy", 32'(bus.Busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.Done) done_seen = 1'b1;
    end
    check("arst_nodone", 32'(done_seen), 32'(0));
    run_op("add22", 4'b1011, 8'h02, 8'h02, 1'b0, 1, 8'h04, 1'b0, 1'b0);

    // Single-cycle ops.
    run_op("addff", 4'b1011, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b1);
    run_op("addci", 4'b1011, 8'h7F, 8'h00, 1'b1, 1, 8'h80, 1'b0, 1'b0);
    run_op("neg",   4'b1010, 8'h01, 8'h00, 1'b0, 1, 8'hFF, 1'b0, 1'b0);
    run_op("geq",   4'b1000, 8'h03, 8'h04, 1'b0, 1, 8'h00, 1'b0, 1'b1);
    run_op("eq",    4'b1001, 8'h02, 8'h02, 1'b0, 1, 8'h01, 1'b0, 1'b0);
    run_op("neq",   4'b1101, 8'h01, 8'h03, 1'b0, 1, 8'h01, 1'b0, 1'b0);
    run_op("lsh",   4'b0000, 8'h01, 8'h00, 1'b1, 1, 8'h03, 1'b0, 1'b0);
    run_op("rsh",   4'b0001, 8'h01, 8'h00, 1'b0, 1, 8'h00, 1'b1, 1'b1);
    run_op("and",   4'b0010, 8'hF0, 8'h3C, 1'b0, 1, 8'h30, 1'b0, 1'b0);
    run_op("or",    4'b0011, 8'hF0, 8'h3C, 1'b0, 1, 8'hFC, 1'b0, 1'b0);
    run_op("undef", 4'b0110, 8'hF0, 8'h3C, 1'b1, 1, 8'h00, 1'b0, 1'b1);

    // Multi-cycle ops.
    run_op("mul13x11", 4'b1100, 8'd13, 8'd11, 1'b0, 9, 8'h8F, 1'b0, 1'b0);
    run_op("mul16x16", 4'b1100, 8'd16, 8'd16, 1'b0, 9, 8'h00, 1'b1, 1'b1);
    run_op("shln3",    4'b0100, 8'h81, 8'd3,  1'b0, 4, 8'h08, 1'b0, 1'b0);
    run_op("shrn1",    4'b0101, 8'h81, 8'd1,  1'b0, 2, 8'h40, 1'b1, 1'b0);
    run_op("shln9",    4'b0100, 8'h81, 8'd9,  1'b0, 9, 8'h00, 1'b1, 1'b1);
    run_op("shln0",    4'b0100, 8'h81, 8'd0,  1'b0, 1, 8'h81, 1'b0, 1'b0);

    // Start pulsed while a MUL is running, inputs changed afterwards.
    start_op(4'b1100, 8'd13, 8'd11, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.OP     = 4'b1011;
    bus.InputA = 8'h01;
    bus.InputB = 8'h01;
    @(posedge clk);
    #1;
    bus.Start  = 1'b0;
    bus.InputA = 8'hFF;
    bus.InputB = 8'hFF;
    check("ign_busy", 32'(bus.Busy), 32'(1));
    wait_done(lat);
    check("ign_lat", 32'(lat + 4), 32'(9));
    check("ign_out", 32'(bus.Out), 32'(8'h8F));
    check("ign_sc",  32'(bus.SC_out), 32'(0));

    // Start held through the Done cycle: second op accepted back-to-back.
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.OP     = 4'b1011;
    bus.InputA = 8'h05;
    bus.InputB = 8'h06;
    bus.SC_in  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("b2b_done1", 32'(bus.Done), 32'(1));
    check("b2b_out1",  32'(bus.Out),  32'(8'h0B));
    @(negedge clk);
    bus.OP     = 4'b0101;
    bus.InputA = 8'h80;
    bus.InputB = 8'd2;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done(lat);
    check("b2b_lat2", 32'(lat), 32'(3));
    check("b2b_out2", 32'(bus.Out), 32'(8'h20));
    check("b2b_sc2",  32'(bus.SC_out), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
